// File: rtl/dec10to8_pkg.sv
// rtl/dec10to8_pkg.sv - 8b/10b decode constants, subblock tables and disparity helpers
package dec10to8_pkg;

    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;

    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] K28_2 = 8'h5C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_6 = 8'hDC;
    localparam logic [7:0] K28_7 = 8'hFC;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;

    typedef enum logic [1:0] {
        DISP_NEUT = 2'd0,
        DISP_POS  = 2'd1,
        DISP_NEG  = 2'd2,
        DISP_BAD  = 2'd3
    } disp_t;

    typedef struct packed {
        logic       valid;
        logic       k28;
        logic [4:0] value;
    } sub6_t;

    typedef struct packed {
        logic       valid;
        logic       a7;
        logic       p7;
        logic [2:0] value;
    } sub4_t;

    // Both running-disparity columns of the 5b/6b table map to the same value.
    function automatic sub6_t lookup_6b(input logic [5:0] c);
        sub6_t r;
        r.valid = 1'b1;
        r.k28   = 1'b0;
        r.value = 5'd0;
        case (c)
            6'b100111, 6'b011000: r.value = 5'd0;
            6'b011101, 6'b100010: r.value = 5'd1;
            6'b101101, 6'b010010: r.value = 5'd2;
            6'b110001:            r.value = 5'd3;
            6'b110101, 6'b001010: r.value = 5'd4;
            6'b101001:            r.value = 5'd5;
            6'b011001:            r.value = 5'd6;
            6'b111000, 6'b000111: r.value = 5'd7;
            6'b111001, 6'b000110: r.value = 5'd8;
            6'b100101:            r.value = 5'd9;
            6'b010101:            r.value = 5'd10;
            6'b110100:            r.value = 5'd11;
            6'b001101:            r.value = 5'd12;
            6'b101100:            r.value = 5'd13;
            6'b011100:            r.value = 5'd14;
            6'b010111, 6'b101000: r.value = 5'd15;
            6'b011011, 6'b100100: r.value = 5'd16;
            6'b100011:            r.value = 5'd17;
            6'b010011:            r.value = 5'd18;
            6'b110010:            r.value = 5'd19;
            6'b001011:            r.value = 5'd20;
            6'b101010:            r.value = 5'd21;
            6'b011010:            r.value = 5'd22;
            6'b111010, 6'b000101: r.value = 5'd23;
            6'b110011, 6'b001100: r.value = 5'd24;
            6'b100110:            r.value = 5'd25;
            6'b010110:            r.value = 5'd26;
            6'b110110, 6'b001001: r.value = 5'd27;
            6'b001110:            r.value = 5'd28;
            6'b101110, 6'b010001: r.value = 5'd29;
            6'b011110, 6'b100001: r.value = 5'd30;
            6'b101011, 6'b010100: r.value = 5'd31;
            6'b001111, 6'b110000: begin
                r.value = 5'd28;
                r.k28   = 1'b1;
            end
            default:              r.valid = 1'b0;
        endcase
        return r;
    endfunction

    function automatic sub4_t lookup_4b(input logic [3:0] c);
        sub4_t r;
        r.valid = 1'b1;
        r.a7    = 1'b0;
        r.p7    = 1'b0;
        r.value = 3'd0;
        case (c)
            4'b1011, 4'b0100: r.value = 3'd0;
            4'b1001:          r.value = 3'd1;
            4'b0101:          r.value = 3'd2;
            4'b1100, 4'b0011: r.value = 3'd3;
            4'b1101, 4'b0010: r.value = 3'd4;
            4'b1010:          r.value = 3'd5;
            4'b0110:          r.value = 3'd6;
            4'b1110, 4'b0001: begin
                r.value = 3'd7;
                r.p7    = 1'b1;
            end
            4'b0111, 4'b1000: begin
                r.value = 3'd7;
                r.a7    = 1'b1;
            end
            default:          r.valid = 1'b0;
        endcase
        return r;
    endfunction

    function automatic disp_t class_6b(input logic [5:0] c);
        int n;
        n = $countones(c);
        if (n == 3)      return DISP_NEUT;
        else if (n == 4) return DISP_POS;
        else if (n == 2) return DISP_NEG;
        else             return DISP_BAD;
    endfunction

    function automatic disp_t class_4b(input logic [3:0] c);
        int n;
        n = $countones(c);
        if (n == 2)      return DISP_NEUT;
        else if (n == 3) return DISP_POS;
        else if (n == 1) return DISP_NEG;
        else             return DISP_BAD;
    endfunction

    function automatic logic next_rd(input logic rd, input disp_t d);
        case (d)
            DISP_POS: return RD_POS;
            DISP_NEG: return RD_NEG;
            default:  return rd;
        endcase
    endfunction

    // 6b prefixes that may legally be followed by A7 = 0111 (ends at RD-).
    function automatic logic a7_lo_ok(input logic [5:0] c);
        case (c)
            6'b100011, 6'b010011, 6'b001011,
            6'b000101, 6'b001001, 6'b010001, 6'b100001, 6'b110000: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // 6b prefixes that may legally be followed by A7 = 1000 (ends at RD+).
    function automatic logic a7_hi_ok(input logic [5:0] c);
        case (c)
            6'b110100, 6'b101100, 6'b011100,
            6'b111010, 6'b110110, 6'b101110, 6'b011110, 6'b001111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic kx7_prefix(input logic [5:0] c);
        case (c)
            6'b111010, 6'b000101, 6'b110110, 6'b001001,
            6'b101110, 6'b010001, 6'b011110, 6'b100001: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // P7 where the encoder would have been forced to use A7 instead.
    function automatic logic p7_conflict(input logic [5:0] c6, input logic [3:0] c4);
        logic lo_set;
        logic hi_set;
        lo_set = (c6 == 6'b100011) || (c6 == 6'b010011) || (c6 == 6'b001011);
        hi_set = (c6 == 6'b110100) || (c6 == 6'b101100) || (c6 == 6'b011100);
        return ((c4 == 4'b1110) && lo_set) || ((c4 == 4'b0001) && hi_set);
    endfunction

endpackage

// File: rtl/dec10to8_dec6to5.sv
// rtl/dec10to8_dec6to5.sv - 6b to 5b subblock decode with disparity classification
module dec6to5
    import dec10to8_pkg::*;
(
    input  logic [5:0] code6,
    input  logic       rd_in,
    output logic [4:0] value5,
    output logic       valid6,
    output logic       k28,
    output disp_t      disp6,
    output logic       rd_mid,
    output logic       disp_err6
);

    sub6_t sub6;

    always_comb begin
        sub6      = lookup_6b(code6);
        value5    = sub6.value;
        valid6    = sub6.valid;
        k28       = sub6.k28;
        disp6     = class_6b(code6);
        rd_mid    = next_rd(rd_in, disp6);
        // Neutral D.7 codes are still polarity-specific.
        disp_err6 = ((disp6 == DISP_POS) && (rd_in == RD_POS)) ||
                    ((disp6 == DISP_NEG) && (rd_in == RD_NEG)) ||
                    ((code6 == 6'b000111) && (rd_in == RD_NEG)) ||
                    ((code6 == 6'b111000) && (rd_in == RD_POS));
    end

endmodule

// File: rtl/dec10to8.sv
// rtl/dec10to8.sv - 8b/10b symbol decoder; DEC10TO8_ERRCNT_EN adds a saturating error counter
module dec10to8
    import dec10to8_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  datain,
    input  logic        valid_in,
    output logic [7:0]  dataout,
    output logic        valid_out,
    output logic        kchar,
    output logic        code_err,
    output logic        disp_err,
`ifdef DEC10TO8_ERRCNT_EN
    output logic        rd_out,
    output logic [15:0] err_cnt
`else
    output logic        rd_out
`endif
);

    logic [5:0] code6;
    logic [3:0] code4;
    logic [3:0] code4_adj;
    logic [4:0] value5;
    logic       valid6;
    logic       k28;
    disp_t      disp6;
    logic       rd_mid;
    logic       disp_err6;
    logic       rd_q;

    sub4_t      sub4;
    disp_t      disp4;
    logic       rd_end;
    logic       disp_err4;
    logic       a7_ok;
    logic       p7_bad;
    logic       kx7;
    logic       sym_code_err;
    logic       sym_disp_err;
    logic       sym_k;
    logic [7:0] sym_byte;

    assign code6  = datain[9:4];
    assign code4  = datain[3:0];
    assign rd_out = rd_q;

    dec6to5 u_dec6to5 (
        .code6     (code6),
        .rd_in     (rd_q),
        .value5    (value5),
        .valid6    (valid6),
        .k28       (k28),
        .disp6     (disp6),
        .rd_mid    (rd_mid),
        .disp_err6 (disp_err6)
    );

    always_comb begin
        // The RD+ form of K28 carries the complemented 4b subblock.
        code4_adj    = (k28 && (code6 == 6'b110000)) ? ~code4 : code4;
        sub4         = lookup_4b(code4_adj);
        disp4        = class_4b(code4);
        rd_end       = next_rd(rd_mid, disp4);
        disp_err4    = ((disp4 == DISP_POS) && (rd_mid == RD_POS)) ||
                       ((disp4 == DISP_NEG) && (rd_mid == RD_NEG)) ||
                       ((code4 == 4'b0011) && (rd_mid == RD_NEG)) ||
                       ((code4 == 4'b1100) && (rd_mid == RD_POS));
        a7_ok        = ((code4 == 4'b0111) && a7_lo_ok(code6)) ||
                       ((code4 == 4'b1000) && a7_hi_ok(code6));
        p7_bad       = p7_conflict(code6, code4) || (sub4.p7 && k28);
        kx7          = sub4.a7 && kx7_prefix(code6);
        sym_code_err = !valid6 || !sub4.valid || (sub4.a7 && !a7_ok) || p7_bad;
        sym_disp_err = disp_err6 || disp_err4;
        sym_k        = k28 || kx7;
        sym_byte     = {sub4.value, value5};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataout   <= 8'h00;
            valid_out <= 1'b0;
            kchar     <= 1'b0;
            code_err  <= 1'b0;
            disp_err  <= 1'b0;
            rd_q      <= RD_NEG;
        end else if (valid_in) begin
            dataout   <= sym_code_err ? 8'h00 : sym_byte;
            valid_out <= 1'b1;
            kchar     <= sym_k && !sym_code_err;
            code_err  <= sym_code_err;
            disp_err  <= sym_disp_err;
            rd_q      <= rd_end;
        end else begin
            valid_out <= 1'b0;
            kchar     <= 1'b0;
            code_err  <= 1'b0;
            disp_err  <= 1'b0;
        end
    end

`ifdef DEC10TO8_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 16'h0000;
        end else if (valid_in && (sym_code_err || sym_disp_err) && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dec10to8.sv
// tb/tb_dec10to8.sv - directed self-checking bench for dec10to8
module tb_dec10to8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [9:0]  datain = 10'd0;
    logic        valid_in = 1'b0;
    logic [7:0]  dataout;
    logic        valid_out;
    logic        kchar;
    logic        code_err;
    logic        disp_err;
    logic        rd_out;
`ifdef DEC10TO8_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    int errors = 0;
    int checks = 0;

    dec10to8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .datain    (datain),
        .valid_in  (valid_in),
        .dataout   (dataout),
        .valid_out (valid_out),
        .kchar     (kchar),
        .code_err  (code_err),
        .disp_err  (disp_err),
`ifdef DEC10TO8_ERRCNT_EN
        .rd_out    (rd_out),
        .err_cnt   (err_cnt)
`else
        .rd_out    (rd_out)
`endif
    );

    always #5 clk = ~clk;

    // {valid_out, dataout, kchar, code_err, disp_err, rd_out}
    wire [12:0] obs = {valid_out, dataout, kchar, code_err, disp_err, rd_out};

    task automatic apply_reset;
        valid_in = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [9:0] d);
        datain = d;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        send(10'b001111_1010);
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 13'h0000) begin
            errors++;
            $display("FAIL reset_async got=%h exp=%h", obs, 13'h0000);
        end
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 13'h0000) begin
            errors++;
            $display("FAIL reset_held got=%h exp=%h", obs, 13'h0000);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_data;
        logic [9:0]  din [4] = '{10'b100111_0100, 10'b010101_0101,
                                 10'b100011_0111, 10'b110100_1000};
        logic [12:0] dexp [4] = '{{1'b1, 8'h00, 4'b0000}, {1'b1, 8'h4A, 4'b0000},
                                  {1'b1, 8'hF1, 4'b0001}, {1'b1, 8'hEB, 4'b0000}};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            send(din[i]);
            checks++;
            if (obs !== dexp[i]) begin
                errors++;
                $display("FAIL data_%0d got=%h exp=%h", i, obs, dexp[i]);
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_kchar;
        apply_reset();
        send(10'b001111_1010);
        checks++;
        if (obs !== {1'b1, 8'hBC, 4'b1001}) begin
            errors++;
            $display("FAIL k28_5_rdneg got=%h exp=%h", obs, {1'b1, 8'hBC, 4'b1001});
        end
        send(10'b110000_0101);
        checks++;
        if (obs !== {1'b1, 8'hBC, 4'b1000}) begin
            errors++;
            $display("FAIL k28_5_rdpos got=%h exp=%h", obs, {1'b1, 8'hBC, 4'b1000});
        end
        send(10'b111010_1000);
        checks++;
        if (obs !== {1'b1, 8'hF7, 4'b1000}) begin
            errors++;
            $display("FAIL k23_7 got=%h exp=%h", obs, {1'b1, 8'hF7, 4'b1000});
        end
        valid_in = 1'b0;
    endtask

    task automatic test_disp_err;
        apply_reset();
        send(10'b011000_1011);
        checks++;
        if (obs !== {1'b1, 8'h00, 4'b0011}) begin
            errors++;
            $display("FAIL disp_neg_at_rdneg got=%h exp=%h", obs, {1'b1, 8'h00, 4'b0011});
        end
        apply_reset();
        send(10'b000111_1011);
        checks++;
        if (obs !== {1'b1, 8'h07, 4'b0011}) begin
            errors++;
            $display("FAIL disp_d7_at_rdneg got=%h exp=%h", obs, {1'b1, 8'h07, 4'b0011});
        end
        valid_in = 1'b0;
    endtask

    task automatic test_code_err;
        apply_reset();
        send(10'b000000_0000);
        checks++;
        if ({dataout, kchar, code_err} !== {8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL code_all_zero got=%h exp=%h", {dataout, kchar, code_err}, {8'h00, 2'b01});
        end
        apply_reset();
        send(10'b100011_1110);
        checks++;
        if (obs !== {1'b1, 8'h00, 4'b0101}) begin
            errors++;
            $display("FAIL code_p7_misuse got=%h exp=%h", obs, {1'b1, 8'h00, 4'b0101});
        end
        send(10'b100011_1110);
        checks++;
        if (obs !== {1'b1, 8'h00, 4'b0111}) begin
            errors++;
            $display("FAIL code_and_disp got=%h exp=%h", obs, {1'b1, 8'h00, 4'b0111});
        end
        valid_in = 1'b0;
    endtask

    task automatic test_idle;
        apply_reset();
        send(10'b001111_1010);
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs !== {1'b0, 8'hBC, 4'b0001}) begin
                errors++;
                $display("FAIL idle_%0d got=%h exp=%h", i, obs, {1'b0, 8'hBC, 4'b0001});
            end
        end
        send(10'b110000_0101);
        checks++;
        if (obs !== {1'b1, 8'hBC, 4'b1000}) begin
            errors++;
            $display("FAIL after_idle got=%h exp=%h", obs, {1'b1, 8'hBC, 4'b1000});
        end
        valid_in = 1'b0;
    endtask

    task automatic test_reset_midstream;
        apply_reset();
        send(10'b001111_1010);
        datain = 10'b110000_0101;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 13'h0000) begin
            errors++;
            $display("FAIL mid_reset got=%h exp=%h", obs, 13'h0000);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(10'b001111_1010);
        checks++;
        if (obs !== {1'b1, 8'hBC, 4'b1001}) begin
            errors++;
            $display("FAIL post_reset_rdneg got=%h exp=%h", obs, {1'b1, 8'hBC, 4'b1001});
        end
        valid_in = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [9:0]  din [6] = '{10'b001111_1010, 10'b101010_1010, 10'b110000_0101,
                                 10'b110001_1011, 10'b110001_0100, 10'b111010_1000};
        logic [12:0] dexp [6] = '{{1'b1, 8'hBC, 4'b1001}, {1'b1, 8'hB5, 4'b0001},
                                  {1'b1, 8'hBC, 4'b1000}, {1'b1, 8'h03, 4'b0001},
                                  {1'b1, 8'h03, 4'b0000}, {1'b1, 8'hF7, 4'b1000}};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            send(din[i]);
            checks++;
            if (obs !== dexp[i]) begin
                errors++;
                $display("FAIL b2b_%0d got=%h exp=%h", i, obs, dexp[i]);
            end
        end
        valid_in = 1'b0;
    endtask

`ifdef DEC10TO8_ERRCNT_EN
    task automatic test_err_cnt;
        apply_reset();
        checks++;
        if (err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL err_cnt_reset got=%h exp=%h", err_cnt, 16'd0);
        end
        for (int i = 0; i < 3; i++) send(10'b000000_0000);
        checks++;
        if (err_cnt !== 16'd3) begin
            errors++;
            $display("FAIL err_cnt_three got=%h exp=%h", err_cnt, 16'd3);
        end
        for (int i = 0; i < 65532; i++) send(10'b000000_0000);
        checks++;
        if (err_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL err_cnt_full got=%h exp=%h", err_cnt, 16'hFFFF);
        end
        send(10'b000000_0000);
        checks++;
        if (err_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL err_cnt_saturate got=%h exp=%h", err_cnt, 16'hFFFF);
        end
        valid_in = 1'b0;
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_data();
        test_kchar();
        test_disp_err();
        test_code_err();
        test_idle();
        test_reset_midstream();
        test_back_to_back();
`ifdef DEC10TO8_ERRCNT_EN
        test_err_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
